spi_master_multi: RTL and testbench
===================================

SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, bits per SPI word (range 4..32).
REQ-002 SHALL have parameter CS_COUNT, default 4, number of chip-select lines (range 1..16).
REQ-003 SHALL have parameter CLK_DIV, default 4, enabled clk cycles per SCLK half-period (minimum 1).
REQ-004 SHALL have port clk, input, 1, single block clock (one clock; reset is asynchronous and active-high).
REQ-005 SHALL have port rst, input, 1, asynchronous reset, active-high.
REQ-006 SHALL have port clk_en, input, 1, clock enable; low freezes all state and outputs.
REQ-007 SHALL have port data_in, input, DATA_WIDTH, word to transmit.
REQ-008 SHALL have port cs_sel, input, $clog2(CS_COUNT) (min 1), target slave index.
REQ-009 SHALL have port cpol, input, 1, SCLK idle level for the transfer.
REQ-010 SHALL have port cpha, input, 1, 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-011 SHALL have port valid_data_in, input, 1, request qualifier for data_in/cs_sel/cpol/cpha.
REQ-012 SHALL have port ready, output, 1, block accepts a request this cycle.
REQ-013 SHALL have port data_out, output, DATA_WIDTH, word received on miso.
REQ-014 SHALL have port valid_data_out, output, 1, one-cycle pulse qualifying data_out.
REQ-015 SHALL have port sclk, output, 1, SPI serial clock.
REQ-016 SHALL have port mosi, output, 1, master-out serial data, MSB first.
REQ-017 SHALL have port miso, input, 1, master-in serial data.
REQ-018 SHALL have port chip_select, output, CS_COUNT, active-low one-cold slave select.

Function
REQ-019 SHALL accept a request when valid_data_in && ready && clk_en, latching data_in, cs_sel, cpol, cpha.
REQ-020 SHALL implement FSM IDLE -> LEAD -> XFER -> TRAIL -> DONE -> IDLE; ready=1 only in IDLE.
REQ-021 SHALL in LEAD drive chip_select[cs_sel] low, sclk=cpol, mosi=MSB, for CLK_DIV enabled cycles.
REQ-022 SHALL in XFER toggle sclk every CLK_DIV enabled cycles, 2*DATA_WIDTH edges total.
REQ-023 SHALL with cpha=0 sample miso on leading edges and shift mosi on trailing edges (except after the last).
REQ-024 SHALL with cpha=1 shift mosi on leading edges and sample miso on trailing edges; mosi=MSB in LEAD.
REQ-025 SHALL in TRAIL hold sclk=cpol and chip_select asserted for CLK_DIV enabled cycles, then deassert all CS.
REQ-026 SHALL in DONE assert valid_data_out for exactly one enabled cycle with the received word on data_out.
REQ-027 SHALL give latency, acceptance to valid_data_out, of (2*DATA_WIDTH+2)*CLK_DIV+1 enabled cycles.
REQ-028 SHALL hold data_out stable from DONE until the next DONE.
REQ-029 SHALL, when cs_sel >= CS_COUNT, run the full transfer with no chip_select asserted.
REQ-030 SHALL ignore valid_data_in while ready=0; no queuing.
REQ-031 SHALL hold sclk at the last latched cpol level in IDLE.

Reset
REQ-032 SHALL on rst force: state IDLE, ready=0 during reset and 1 the first enabled cycle after, valid_data_out=0, data_out=0, sclk=0, mosi=0, chip_select all ones.
REQ-033 SHALL abort any transfer on rst mid-operation, deasserting all CS immediately with no valid_data_out pulse.

Configuration
REQ-034 SHALL with macro SPI_MASTER_LOOPBACK_EN defined route mosi internally to the receive shifter in place of miso; miso ignored.
REQ-035 SHALL without SPI_MASTER_LOOPBACK_EN sample the miso port; no loopback logic present.

Structure
REQ-036 SHALL place the FSM state enum (IDLE, LEAD, XFER, TRAIL, DONE) and an SPI mode typedef {cpol, cpha} in package spi_pkg.
REQ-037 SHALL implement the half-period counter and edge strobes (leading/trailing pulse) in sub-module spi_clk_gen.

Verification
REQ-038 SHALL cover: DATA_WIDTH=8, CLK_DIV=2, mode 0, loopback, data_in=0xA5 -> data_out=0xA5, valid_data_out 37 enabled cycles after acceptance.
REQ-039 SHALL cover: mode 3 (cpol=1, cpha=1), slave model returns 0x3C, cs_sel=2 -> chip_select=4'b1011 during transfer, data_out=0x3C, sclk idles high.
REQ-040 SHALL cover: clk_en held low for 5 cycles mid-XFER -> sclk, mosi, chip_select frozen; latency extends by exactly 5 cycles.
REQ-041 SHALL cover: rst asserted at edge 7 of 16 -> chip_select=4'b1111 same cycle, no valid_data_out, next request completes normally.
REQ-042 SHALL cover: cs_sel=5 with CS_COUNT=4 -> chip_select stays 4'b1111, valid_data_out still pulses once.
REQ-043 SHALL cover: valid_data_in held high continuously -> back-to-back transfers, each accepted in IDLE only, one valid_data_out pulse per transfer.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the multi-slave SPI master: FSM states, SPI mode pair,
// and the chip-select index width helper.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_XFER,
    ST_TRAIL,
    ST_DONE
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Slave index width: enough bits for CS_COUNT slaves plus one spare bit,
  // so an out-of-range index can be requested and runs with no CS asserted.
  function automatic int cs_sel_width(input int cs_count);
    return ((cs_count > 1) ? $clog2(cs_count) : 1) + 1;
  endfunction

endpackage

// File: rtl/spi_master_multi_if.sv
// Request/response and SPI pin bundle for spi_master_multi.
// master modport: the SPI master block; slave modport: the user/board side.
interface spi_master_multi_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CS_COUNT   = 4
);
  localparam int CS_SEL_W = spi_pkg::cs_sel_width(CS_COUNT);

  logic                  clk_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [CS_SEL_W-1:0]   cs_sel;
  logic                  cpol;
  logic                  cpha;
  logic                  valid_data_in;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_data_out;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;
  logic [CS_COUNT-1:0]   chip_select;

  modport master (
    input  clk_en, data_in, cs_sel, cpol, cpha, valid_data_in, miso,
    output ready, data_out, valid_data_out, sclk, mosi, chip_select
  );

  modport slave (
    output clk_en, data_in, cs_sel, cpol, cpha, valid_data_in, miso,
    input  ready, data_out, valid_data_out, sclk, mosi, chip_select
  );

endinterface

// File: rtl/spi_clk_gen.sv
// SCLK half-period timer. Counts CLK_DIV enabled cycles per half period while
// run_i is high and flags the end of each (tick_o). During XFER it alternates
// between leading and trailing edge strobes, starting with a leading edge.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en_i,
  input  logic run_i,
  input  logic xfer_i,
  output logic tick_o,
  output logic lead_o,
  output logic trail_o
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  // Next-state for the half-period counter and the leading/trailing phase.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!run_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      if (xfer_i) phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and phase registers, frozen while clk_en_i is low.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (clk_en_i) begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign tick_o  = run_i && (cnt_q == LAST);
  assign lead_o  = tick_o && xfer_i && !phase_q;
  assign trail_o = tick_o && xfer_i && phase_q;

endmodule

// File: rtl/spi_master_multi.sv
// Multi-slave SPI master, one word per request, MSB first, per-request
// CPOL/CPHA. Define SPI_MASTER_LOOPBACK_EN to feed mosi back into the receive
// shifter instead of the miso pin.
module spi_master_multi
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CS_COUNT   = 4,
  parameter int CLK_DIV    = 4
) (
  input logic                clk,
  input logic                rst,
  spi_master_multi_if.master bus
);

  localparam int CSW = cs_sel_width(CS_COUNT);
  localparam int EW  = $clog2(2 * DATA_WIDTH);

  spi_state_e            state_q;
  spi_mode_t             mode_q;
  logic [DATA_WIDTH-1:0] tx_sr_q;
  logic [DATA_WIDTH-1:0] rx_sr_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [EW-1:0]         edge_cnt_q;
  logic [CS_COUNT-1:0]   cs_n_q;
  logic                  sclk_q, mosi_q, ready_q, valid_q;

  logic tick, lead, trail, run, xfer, last_edge, rx_bit;

  // One-cold select pattern; indices outside the slave range select nobody.
  function automatic logic [CS_COUNT-1:0] cs_decode(input logic [CSW-1:0] idx);
    cs_decode = '1;
    for (int i = 0; i < CS_COUNT; i++) begin
      if (idx == CSW'(i)) cs_decode[i] = 1'b0;
    end
  endfunction

  assign run       = (state_q == ST_LEAD) || (state_q == ST_XFER) || (state_q == ST_TRAIL);
  assign xfer      = (state_q == ST_XFER);
  assign last_edge = (edge_cnt_q == EW'(2 * DATA_WIDTH - 1));

`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_bit = mosi_q;
`else
  assign rx_bit = bus.miso;
`endif

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .clk_en_i (bus.clk_en),
    .run_i    (run),
    .xfer_i   (xfer),
    .tick_o   (tick),
    .lead_o   (lead),
    .trail_o  (trail)
  );

  // Transfer FSM with registered pin and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      data_out_q <= '0;
      edge_cnt_q <= '0;
      cs_n_q     <= '1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else if (bus.clk_en) begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (bus.valid_data_in && ready_q) begin
            ready_q    <= 1'b0;
            mode_q     <= '{cpol: bus.cpol, cpha: bus.cpha};
            sclk_q     <= bus.cpol;
            mosi_q     <= bus.data_in[DATA_WIDTH-1];
            // CPHA=1 re-drives the MSB on the first leading edge, so its
            // shifter still holds the MSB; CPHA=0 has already presented it.
            tx_sr_q    <= bus.cpha ? bus.data_in : (bus.data_in << 1);
            cs_n_q     <= cs_decode(bus.cs_sel);
            edge_cnt_q <= '0;
            state_q    <= ST_LEAD;
          end
        end
        ST_LEAD: begin
          if (tick) state_q <= ST_XFER;
        end
        ST_XFER: begin
          if (tick) begin
            sclk_q     <= ~sclk_q;
            edge_cnt_q <= edge_cnt_q + 1'b1;
            if (lead) begin
              if (!mode_q.cpha) begin
                rx_sr_q <= {rx_sr_q[DATA_WIDTH-2:0], rx_bit};
              end else begin
                mosi_q  <= tx_sr_q[DATA_WIDTH-1];
                tx_sr_q <= tx_sr_q << 1;
              end
            end
            if (trail) begin
              if (mode_q.cpha) begin
                rx_sr_q <= {rx_sr_q[DATA_WIDTH-2:0], rx_bit};
              end else if (!last_edge) begin
                mosi_q  <= tx_sr_q[DATA_WIDTH-1];
                tx_sr_q <= tx_sr_q << 1;
              end
            end
            if (last_edge) state_q <= ST_TRAIL;
          end
        end
        ST_TRAIL: begin
          if (tick) begin
            cs_n_q     <= '1;
            data_out_q <= rx_sr_q;
            valid_q    <= 1'b1;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready          = ready_q;
  assign bus.data_out       = data_out_q;
  assign bus.valid_data_out = valid_q;
  assign bus.sclk           = sclk_q;
  assign bus.mosi           = mosi_q;
  assign bus.chip_select    = cs_n_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Self-checking bench for spi_master_multi (DATA_WIDTH=8, CS_COUNT=4, CLK_DIV=2).
// A behavioural SPI slave follows sclk per CPOL/CPHA; loopback is formed by
// wiring miso to mosi outside the DUT.
module tb_spi_master_multi;
  import spi_pkg::*;

  localparam int DW  = 8;
  localparam int CSN = 4;
  localparam int DIV = 2;
  localparam int CSW = cs_sel_width(CSN);
  localparam int LAT = (2 * DW + 2) * DIV + 1;
  localparam logic [CSN-1:0] CS_NONE = {CSN{1'b1}};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_master_multi_if #(.DATA_WIDTH(DW), .CS_COUNT(CSN)) bus ();

  spi_master_multi #(.DATA_WIDTH(DW), .CS_COUNT(CSN), .CLK_DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural slave state
  logic          tb_loop = 1'b0;
  logic          slv_en  = 1'b0;
  logic          slv_miso = 1'b0;
  logic          s_cpol = 1'b0, s_cpha = 1'b0;
  logic [DW-1:0] slv_word = '0, slv_rx = '0;
  int            slv_edges = 0, slv_idx = 0;

  assign bus.miso = tb_loop ? bus.mosi : slv_miso;

  // Slave: sample mosi on its sampling edge, present next bit on its shift edge.
  always @(bus.sclk) begin
    if (slv_en) begin
      slv_edges++;
      if ((bus.sclk != s_cpol) != s_cpha) begin
        slv_rx = {slv_rx[DW-2:0], bus.mosi};
      end else if (slv_idx >= 0) begin
        slv_miso = slv_word[slv_idx];
        slv_idx--;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One request; optional clk_en freeze and reset abort at a given sclk edge.
  task automatic xfer(input logic [DW-1:0] din, input logic [CSW-1:0] cs_idx,
                      input logic cp, input logic ph, input logic [DW-1:0] sword,
                      input logic loop, input logic hold, input int frz_at,
                      input int frz_len, input int abort_edge, input string tag);
    logic [CSN-1:0] exp_cs;
    logic [DW-1:0]  exp_rx;
    logic [CSN+1:0] frz_snap;
    int  ps, frz_left, cs_bad, rdy_bad, frz_bad, wait_n, rst_bad;
    bit  got;
    exp_cs = CS_NONE;
    if (int'(cs_idx) < CSN) exp_cs[cs_idx] = 1'b0;
    exp_rx = loop ? din : sword;

    tb_loop = loop; s_cpol = cp; s_cpha = ph; slv_word = sword; slv_rx = '0;
    slv_miso = sword[DW-1]; slv_idx = ph ? DW - 1 : DW - 2; slv_edges = 0;
    bus.data_in = din; bus.cs_sel = cs_idx; bus.cpol = cp; bus.cpha = ph;
    bus.valid_data_in = 1'b1;
    wait_n = 0;
    while (bus.ready !== 1'b1 && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    check({tag, " accept_wait"}, 32'(wait_n < 100), 1);
    if (wait_n >= 100) return;
    if (hold) check({tag, " accept_immediate"}, wait_n, 0);
    @(negedge clk);
    if (!hold) bus.valid_data_in = 1'b0;
    slv_en = 1'b1;
    check({tag, " lead_sclk"}, bus.sclk, cp);
    check({tag, " lead_mosi"}, bus.mosi, din[DW-1]);

    ps = 1; got = 0; cs_bad = 0; rdy_bad = 0; frz_bad = 0; frz_left = 0;
    while (!got && ps < 300) begin
      if (abort_edge > 0 && slv_edges == abort_edge) begin
        slv_en = 1'b0;
        rst = 1'b1;
        #1;
        check({tag, " abort_cs"}, bus.chip_select, CS_NONE);
        rst_bad = 0;
        repeat (4) begin
          @(negedge clk);
          if (bus.valid_data_out !== 1'b0 || bus.ready !== 1'b0) rst_bad++;
        end
        check({tag, " abort_no_valid"}, rst_bad, 0);
        bus.valid_data_in = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check({tag, " ready_after_abort"}, bus.ready, 1);
        return;
      end
      if (bus.valid_data_out === 1'b1) begin
        got = 1;
      end else begin
        if (bus.chip_select !== exp_cs) cs_bad++;
        if (bus.ready !== 1'b0) rdy_bad++;
        if (frz_left > 0) begin
          if ({bus.sclk, bus.mosi, bus.chip_select} !== frz_snap) frz_bad++;
          frz_left--;
          if (frz_left == 0) bus.clk_en = 1'b1;
        end else if (frz_len > 0 && ps == frz_at) begin
          frz_snap = {bus.sclk, bus.mosi, bus.chip_select};
          frz_left = frz_len;
          bus.clk_en = 1'b0;
        end
        @(negedge clk);
        ps++;
      end
    end
    bus.clk_en = 1'b1;
    check({tag, " completed"}, 32'(got), 1);
    if (got) begin
      slv_en = 1'b0;
      check({tag, " latency"}, ps, LAT + frz_len);
      check({tag, " data_out"}, bus.data_out, exp_rx);
      check({tag, " sclk_edges"}, slv_edges, 2 * DW);
      check({tag, " mosi_word"}, slv_rx, din);
      check({tag, " cs_during"}, cs_bad, 0);
      check({tag, " ready_busy"}, rdy_bad, 0);
      check({tag, " cs_done"}, bus.chip_select, CS_NONE);
      if (frz_len > 0) check({tag, " frozen_pins"}, frz_bad, 0);
      @(negedge clk);
      check({tag, " valid_one_cycle"}, bus.valid_data_out, 0);
      check({tag, " idle_sclk"}, bus.sclk, cp);
      check({tag, " idle_ready"}, bus.ready, 1);
      check({tag, " data_out_hold"}, bus.data_out, exp_rx);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.clk_en = 1'b1; bus.valid_data_in = 1'b0; bus.data_in = '0;
    bus.cs_sel = '0; bus.cpol = 1'b0; bus.cpha = 1'b0;
    repeat (3) @(negedge clk);
    check("rst ready", bus.ready, 0);
    check("rst valid", bus.valid_data_out, 0);
    check("rst data_out", bus.data_out, 0);
    check("rst sclk", bus.sclk, 0);
    check("rst mosi", bus.mosi, 0);
    check("rst cs", bus.chip_select, CS_NONE);
    rst = 1'b0;
    @(negedge clk);
    check("ready after reset", bus.ready, 1);

    xfer(8'hA5, CSW'(0), 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 0, "loop_a5");
    xfer(DW'($urandom), CSW'(2), 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 0, 0, 0, "mode3");
    xfer(DW'($urandom), CSW'(1), 1'b0, 1'b0, DW'($urandom), 1'b0, 1'b0, 12, 5, 0, "freeze");
    xfer(DW'($urandom), CSW'(3), 1'b0, 1'b1, DW'($urandom), 1'b0, 1'b0, 0, 0, 7, "abort");
    xfer(DW'($urandom), CSW'(3), 1'b0, 1'b1, DW'($urandom), 1'b0, 1'b0, 0, 0, 0, "post_abort");
    xfer(DW'($urandom), CSW'(5), 1'b1, 1'b0, DW'($urandom), 1'b0, 1'b0, 0, 0, 0, "cs_out_of_range");
    for (int i = 0; i < 3; i++) begin
      xfer(DW'($urandom), CSW'($urandom_range(0, CSN - 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), DW'($urandom), 1'b0, 1'b1, 0, 0, 0, "back_to_back");
    end
    bus.valid_data_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      xfer(DW'($urandom), CSW'($urandom_range(0, CSN)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0,
           0, 0, 0, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
